// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the product accumulation stage.
package mult_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int unsigned PROD_W        = 32;
   localparam int unsigned DEF_BLOCK_LEN = 8;
   localparam int unsigned DEF_ACC_W     = 34;

endpackage

// File: rtl/mult_acc_stage_acc_sat_add.sv
// Combinational accumulator adder with carry-out handling.
// Build option MULT_ACC_SATURATE_EN selects clamping; otherwise wraps with a sticky overflow flag.
module acc_sat_add
   import mult_acc_pkg::*;
#(
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  sum,
   input  logic [PROD_W-1:0] addend,
   input  logic              flag,
   output logic [ACC_W-1:0]  sum_nxt,
   output logic              flag_nxt
);

   logic [ACC_W:0] raw;

   always_comb begin
      raw = {1'b0, sum} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
`ifdef MULT_ACC_SATURATE_EN
      // Once clamped the sum stays pinned for the rest of the block.
      if (flag || raw[ACC_W]) begin
         sum_nxt  = '1;
         flag_nxt = 1'b1;
      end else begin
         sum_nxt  = raw[ACC_W-1:0];
         flag_nxt = 1'b0;
      end
`else
      sum_nxt  = raw[ACC_W-1:0];
      flag_nxt = flag | raw[ACC_W];
`endif
   end

endmodule

// File: rtl/mult_acc_stage.sv
// Accumulates blocks of 32-bit products and presents each block sum on a registered valid/ready output.
// Carry behaviour is chosen in acc_sat_add via MULT_ACC_SATURATE_EN.
module mult_acc_stage
   import mult_acc_pkg::*;
#(
   parameter int unsigned BLOCK_LEN = DEF_BLOCK_LEN,
   parameter int unsigned ACC_W     = DEF_ACC_W,
   parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_p,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   sum, sum_nxt, sum_upd, add_sum;
   logic [CNT_W-1:0]   count, cnt_nxt, cnt_upd;
   logic               ovf, ovf_nxt, ovf_upd, add_flag;
   logic               ov_nxt, oovf_nxt;
   logic [ACC_W-1:0]   osum_nxt;
   logic [CNT_W-1:0]   ocnt_nxt;
   logic               accept;

   assign in_ready = (state == ACCUM);
   assign accept   = in_ready & in_valid;

   acc_sat_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .sum      (sum),
      .addend   (in_p),
      .flag     (ovf),
      .sum_nxt  (add_sum),
      .flag_nxt (add_flag)
   );

   always_comb begin
      state_nxt = state;
      sum_nxt   = sum;
      cnt_nxt   = count;
      ovf_nxt   = ovf;
      ov_nxt    = out_valid;
      osum_nxt  = out_sum;
      ocnt_nxt  = out_count;
      oovf_nxt  = out_ovf;
      cnt_upd   = count + CNT_W'(accept);
      sum_upd   = accept ? add_sum  : sum;
      ovf_upd   = accept ? add_flag : ovf;
      case (state)
         ACCUM: begin
            // cnt_upd is non-zero iff beats are pending, including one accepted this cycle.
            if ((accept && cnt_upd == CNT_W'(BLOCK_LEN)) || (flush && cnt_upd != '0)) begin
               osum_nxt  = sum_upd;
               ocnt_nxt  = cnt_upd;
               oovf_nxt  = ovf_upd;
               ov_nxt    = 1'b1;
               sum_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
               state_nxt = HOLD;
            end else begin
               sum_nxt = sum_upd;
               cnt_nxt = cnt_upd;
               ovf_nxt = ovf_upd;
            end
         end
         HOLD: begin
            if (out_ready) begin
               ov_nxt    = 1'b0;
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         sum       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state     <= state_nxt;
         sum       <= sum_nxt;
         count     <= cnt_nxt;
         ovf       <= ovf_nxt;
         out_valid <= ov_nxt;
         out_sum   <= osum_nxt;
         out_count <= ocnt_nxt;
         out_ovf   <= oovf_nxt;
      end
   end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Self-checking bench for mult_acc_stage: table-driven blocks with a result scoreboard plus hand-written corner sequences.
module tb_mult_acc_stage;

   localparam int unsigned BL = 8;
   localparam int unsigned AW = 34;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, flush, out_valid, out_ready, out_ovf;
   logic [31:0]   in_p;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_count;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [AW-1:0] sum;
      logic [CW-1:0] cnt;
      logic          ovf;
   } res_t;

   typedef struct {
      logic [31:0]   p;
      logic [31:0]   step;
      int unsigned   n;
      logic          fl;
      logic [AW-1:0] sum;
      logic [CW-1:0] cnt;
      logic          ovf;
   } vec_t;

   res_t q[$];
   vec_t vecs[6];

   mult_acc_stage #(
      .BLOCK_LEN (BL),
      .ACC_W     (AW),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: a result is consumed on any edge where out_valid and out_ready are both high.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got sum 0x%0h count %0d, expected none", out_sum, out_count);
         end else begin
            res_t e;
            e = q.pop_front();
            chk("out_sum",   64'(out_sum),   64'(e.sum));
            chk("out_count", 64'(out_count), 64'(e.cnt));
            chk("out_ovf",   64'(out_ovf),   64'(e.ovf));
         end
      end
   end

   task automatic beat(input logic [31:0] p, input logic fl);
      int unsigned waited = 0;
      in_valid = 1'b1;
      in_p     = p;
      flush    = fl;
      while (!in_ready && waited < 20) begin
         @(posedge clk) #1;
         waited++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
      end
      @(posedge clk) #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input logic push);
      res_t r;
      if (push) begin
         r.sum = v.sum;
         r.cnt = v.cnt;
         r.ovf = v.ovf;
         q.push_back(r);
      end
      for (int unsigned i = 0; i < v.n; i++)
         beat(v.p + v.step * i, (i == v.n - 1) ? v.fl : 1'b0);
   endtask

   initial begin
      vecs[0] = '{p: 32'd1,          step: 32'd1, n: 8, fl: 1'b0, sum: 34'd36,          cnt: 4'd8, ovf: 1'b0};
      vecs[1] = '{p: 32'hFFFE_0001, step: 32'd0, n: 3, fl: 1'b1, sum: 34'h2_FFFA_0003, cnt: 4'd3, ovf: 1'b0};
`ifdef MULT_ACC_SATURATE_EN
      vecs[2] = '{p: 32'hFFFE_0001, step: 32'd0, n: 8, fl: 1'b0, sum: 34'h3_FFFF_FFFF, cnt: 4'd8, ovf: 1'b1};
      vecs[5] = '{p: 32'hFFFF_FFFF, step: 32'd0, n: 5, fl: 1'b1, sum: 34'h3_FFFF_FFFF, cnt: 4'd5, ovf: 1'b1};
`else
      vecs[2] = '{p: 32'hFFFE_0001, step: 32'd0, n: 8, fl: 1'b0, sum: 34'h3_FFF0_0008, cnt: 4'd8, ovf: 1'b1};
      vecs[5] = '{p: 32'hFFFF_FFFF, step: 32'd0, n: 5, fl: 1'b1, sum: 34'h0_FFFF_FFFB, cnt: 4'd5, ovf: 1'b1};
`endif
      vecs[3] = '{p: 32'd5,          step: 32'd0, n: 1, fl: 1'b1, sum: 34'd5,           cnt: 4'd1, ovf: 1'b0};
      vecs[4] = '{p: 32'hFFFF_FFFF, step: 32'd0, n: 4, fl: 1'b1, sum: 34'h3_FFFF_FFFC, cnt: 4'd4, ovf: 1'b0};

      // Reset held two cycles with in_valid high.
      rst = 1'b1; in_valid = 1'b1; in_p = 32'd123; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sum",   64'(out_sum),   64'd0);
      chk("rst_out_count", 64'(out_count), 64'd0);
      chk("rst_out_ovf",   64'(out_ovf),   64'd0);
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_in_ready",  64'(in_ready),  64'd1);

      foreach (vecs[i]) run_vec(vecs[i], 1'b1);

      // Full block: HOLD lasts exactly one cycle with out_ready high.
      @(posedge clk) #1;
      run_vec(vecs[0], 1'b1);
      chk("full_hold_in_ready",  64'(in_ready),  64'd0);
      chk("full_hold_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk) #1;
      chk("full_after_in_ready",  64'(in_ready),  64'd1);
      chk("full_after_out_valid", 64'(out_valid), 64'd0);

      // Lone flush after a flushed block produces nothing.
      run_vec(vecs[1], 1'b1);
      @(posedge clk) #1;
      flush = 1'b1;
      @(posedge clk) #1;
      flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("lone_flush_out_valid", 64'(out_valid), 64'd0);
      chk("lone_flush_in_ready",  64'(in_ready),  64'd1);

      // Backpressure: held result stays stable and no beat is absorbed.
      out_ready = 1'b0;
      for (int unsigned i = 0; i < BL; i++) beat(32'd1, 1'b0);
      in_valid = 1'b1; in_p = 32'd7;
      for (int unsigned i = 0; i < 5; i++) begin
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready",  64'(in_ready),  64'd0);
         chk("bp_out_sum",   64'(out_sum),   64'd8);
         chk("bp_out_count", 64'(out_count), 64'd8);
         @(posedge clk) #1;
      end
      q.push_back('{sum: 34'd8, cnt: 4'd8, ovf: 1'b0});
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk) #1;
      q.push_back('{sum: 34'd24, cnt: 4'd8, ovf: 1'b0});
      for (int unsigned i = 0; i < BL; i++) beat(32'd3, 1'b0);

      // Mid-block reset discards the partial sum.
      @(posedge clk) #1;
      for (int unsigned i = 0; i < 4; i++) beat(32'd10, 1'b0);
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      q.push_back('{sum: 34'd16, cnt: 4'd8, ovf: 1'b0});
      for (int unsigned i = 0; i < BL; i++) beat(32'd2, 1'b0);

      // Reset while holding a result drops it.
      @(posedge clk) #1;
      out_ready = 1'b0;
      beat(32'd9, 1'b1);
      chk("hold_pre_rst_out_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      chk("hold_rst_out_valid", 64'(out_valid), 64'd0);
      chk("hold_rst_out_sum",   64'(out_sum),   64'd0);
      chk("hold_rst_in_ready",  64'(in_ready),  64'd1);
      out_ready = 1'b1;

      for (int unsigned i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d results missing, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_acc_stage.md
# mult_acc_stage

Downstream consumer of the 16×16 unsigned multiplier's 32-bit product `P`. It accumulates a block of products into a wider unsigned sum using a valid/ready input handshake. It then presents the block result on a registered valid/ready output. Blocks close either after a fixed beat count or on an early `flush`.

## Interface
Parameters:
- `BLOCK_LEN`, default 8: number of products per block; must be ≥ 2.
- `ACC_W`, default 34: accumulator width; must be ≥ 32.
- `CNT_W`, default $clog2(BLOCK_LEN+1): width of the beat counter and `out_count`.

Ports:
- `clk`, input, 1: the single clock; everything is on its rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `in_valid`, input, 1: product beat present.
- `in_ready`, output, 1: stage can accept a beat.
- `in_p`, input, 32: unsigned product, the multiplier's `P`.
- `flush`, input, 1: close the current partial block.
- `out_valid`, output, 1: block result valid.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, ACC_W: block sum.
- `out_count`, output, CNT_W: number of beats in the block.
- `out_ovf`, output, 1: the block exceeded 2^ACC_W−1.

## Operation
- Two states: ACCUM and HOLD.
- Reset state: ACCUM.
  - Internal sum, count and overflow flag are 0.
  - Outputs: `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0, `in_ready`=1.
- ACCUM:
  - `in_ready`=1.
  - A beat is accepted when `in_valid`=1: sum ← sum + zero-extended `in_p`, and count ← count+1.
  - The block closes when either condition below holds:
    - count reaches `BLOCK_LEN` on an accepted beat;
    - `flush`=1 with (count>0 or a beat accepted that cycle).
  - A beat accepted in the same cycle as `flush` is included in the closing block.
  - `flush` with count=0 and no accepted beat is ignored.
  - On close: `out_sum`, `out_count` and `out_ovf` load the updated values, `out_valid`←1, and the state goes to HOLD.
  - Internal sum, count and flag clear on close.
- HOLD:
  - `in_ready`=0; `in_valid` and `flush` are ignored.
  - The outputs hold stable until `out_ready`=1.
  - On that edge: `out_valid`←0 and the state returns to ACCUM.
  - `out_sum`, `out_count` and `out_ovf` keep their last values; they are only meaningful while `out_valid`=1.
- Arithmetic: unsigned, ACC_W+1-bit internal add. Carry-out is handled per Configuration.
- Reset mid-block or in HOLD: the partial sum is discarded, the pending result is dropped, and every output returns to its reset value on the next edge.

## Timing
- `out_valid` rises on the edge that accepts the closing beat, or on the edge that samples `flush`. Latency is 0 cycles after acceptance; the output is registered.
- Minimum HOLD occupancy is 1 cycle.
- Full-rate throughput is one block per BLOCK_LEN+1 cycles when `out_ready` is tied high.
- `in_ready` is a function of state only. It has no combinational path from `out_ready` or `in_valid`.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Configuration
- Macro `MULT_ACC_SATURATE_EN`.
- Defined (saturating): on carry-out the sum clamps to 2^ACC_W−1 and stays there for the rest of the block, and `out_ovf`=1.
- Undefined (wrapping): the sum wraps modulo 2^ACC_W; `out_ovf`=1 if any carry-out occurred in the block (sticky per block).

## Structure
- Package `mult_acc_pkg` holds:
  - the state enum (ACCUM, HOLD);
  - `PROD_W`=32;
  - default `BLOCK_LEN`/`ACC_W` constants.
- One sub-module, `acc_sat_add`: combinational ACC_W adder.
  - Inputs: sum, 32-bit addend, sticky flag.
  - Outputs: next sum and next flag.
  - Contains the `MULT_ACC_SATURATE_EN` selection, so the FSM is identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0; `in_ready`=1 after release.
- Full block: 8 back-to-back beats `in_p`=1..8, `out_ready`=1 → `out_valid` for 1 cycle after the 8th beat, `out_sum`=36, `out_count`=8, `out_ovf`=0; `in_ready`=0 for exactly 1 cycle.
- Flush: 3 beats of 0xFFFE0001, with `flush` asserted alongside the 3rd beat → `out_sum`=0x2_FFFA_0003, `out_count`=3. A following lone `flush` with no beats → no result.
- Overflow: 8 beats of 0xFFFE0001.
  - Without macro: `out_sum`=0x3_FFF0_0008, `out_ovf`=1.
  - With macro: `out_sum`=0x3_FFFF_FFFF, `out_ovf`=1.
- Backpressure: close a block with `out_ready`=0 for 5 cycles while driving `in_valid`=1, `in_p`=7 → outputs stable, `in_ready`=0, no beat absorbed. The next block starts at sum 0 after `out_ready`.
- Mid-block reset: 4 beats of 10, then `rst` for 1 cycle, then 8 beats of 2 → single result `out_sum`=16, `out_count`=8.
